mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage: holds load data, ALU result, destination register and WB control.
//  Adds valid/ready backpressure through a 2-entry skid buffer, synchronous flush and a stall-cycle counter.
//  Sits between the data-memory stage and the register-file write port.
//  Bubbles never carry an asserted WB control bit.
// PARAMETERS
//  DATA_W   32  width of mem_data and alu_result
//  REG_W     5  width of destination register index
//  CTRL_W    2  WB control bits; bit0 = MemToReg, bit1 = RegWrite
//  CNT_W    16  stall counter width (saturating)
// PORTS
//  clock          in   1       rising-edge clock
//  reset_n        in   1       asynchronous, active-low reset
//  flush          in   1       discard all held entries at next edge
//  in_valid       in   1       upstream entry present
//  in_ready       out  1       stage can accept (registered)
//  in_mem_data    in   DATA_W  load data
//  in_alu_result  in   DATA_W  ALU result
//  in_reg_dest    in   REG_W   destination register
//  in_ctrl        in   CTRL_W  WB control
//  out_valid      out  1       entry presented to WB
//  out_ready      in   1       WB consumes entry
//  out_mem_data   out  DATA_W
//  out_alu_result out  DATA_W
//  out_reg_dest   out  REG_W
//  out_ctrl       out  CTRL_W  forced 0 when out_valid=0
//  stall_cycles   out  CNT_W   cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0, except in_ready=1. Both entries invalid.
//    Reset mid-transfer drops the held data.
//  - Handshake: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//  - out_valid must not depend combinationally on out_ready; payload is stable while out_valid & !out_ready.
//  - Latency: 1 cycle from input transfer to out_valid, when the stage is empty or draining.
//  - States (occupancy):
//      EMPTY: main invalid, skid invalid.
//      ONE:   main valid, skid invalid.
//      FULL:  main valid, skid valid; in_ready=0.
//  - Transitions:
//      EMPTY + in xfer              -> ONE
//      ONE   + in & out xfer        -> ONE, main <= input
//      ONE   + out xfer only        -> EMPTY
//      ONE   + in xfer only         -> FULL, skid <= input
//      FULL  + out xfer             -> ONE, main <= skid
//  - in_ready = !skid_valid, registered. This is why an input can arrive in ONE while out_ready=0.
//  - Flush has priority over everything: next state EMPTY, and any input accepted in the flush cycle
//    is discarded. in_ready=1 after a flush.
//  - Payload registers keep stale data when invalid; out_ctrl is masked to 0 whenever out_valid=0.
//  - stall_cycles increments once per cycle with out_valid & !out_ready.
//      - It saturates at 2^CNT_W-1 (no wrap).
//      - It is cleared only by reset; flush does not clear it.
//  - Simultaneous flush and stall: the counter counts that cycle.
// STRUCTURE
//  - Shared package pipe_pkg:
//      CTRL_MEMTOREG=0, CTRL_REGWRITE=1 bit indices;
//      localparam/function for payload width 2*DATA_W+REG_W+CTRL_W.
//  - One sub-module skid_buffer #(W): generic 2-entry valid/ready skid buffer with flush.
//      - The stage packs the payload, instantiates skid_buffer, masks ctrl and owns the stall counter.
// TESTING
//  - Reset: drive reset_n=0 mid-stream -> immediately out_valid=0, out_ctrl=0, stall_cycles=0, in_ready=1.
//  - Streaming: out_ready=1; in_alu_result=0x1,0x2,0x3 on consecutive cycles
//      -> out_alu_result 0x1,0x2,0x3 one cycle later, no gaps.
//  - Backpressure: out_ready=0 with two entries sent (0xA then 0xB)
//      -> in_ready=0 after the second; outputs hold 0xA.
//      -> Raising out_ready delivers 0xA then 0xB, in order.
//  - Flush while FULL with in_valid=1, in_ctrl=2'b10
//      -> next cycle out_valid=0, out_ctrl=0, in_ready=1; the flushed input never appears.
//  - Counter: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cycles saturates at 15.
//  - Bubble: in_valid=0 with in_ctrl=2'b11 -> out_ctrl stays 0, no RegWrite seen.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared MEM/WB definitions: WB control bit positions, skid-buffer occupancy
// states and the packed payload width.
package pipe_pkg;

  localparam int unsigned CTRL_MEMTOREG = 0;
  localparam int unsigned CTRL_REGWRITE = 1;

  typedef enum logic [1:0] {
    SB_EMPTY,
    SB_ONE,
    SB_FULL
  } sb_state_t;

  function automatic int unsigned payload_w(int unsigned data_w, int unsigned reg_w,
                                            int unsigned ctrl_w);
    return 2 * data_w + reg_w + ctrl_w;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB handshake bundle: upstream valid/ready with payload, downstream valid/ready with payload.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 2
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_mem_data;
  logic [DATA_W-1:0] in_alu_result;
  logic [REG_W-1:0]  in_reg_dest;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mem_data;
  logic [DATA_W-1:0] out_alu_result;
  logic [REG_W-1:0]  out_reg_dest;
  logic [CTRL_W-1:0] out_ctrl;

  // Memory stage and WB port side
  modport master (
    output in_valid, in_mem_data, in_alu_result, in_reg_dest, in_ctrl, out_ready,
    input  in_ready, out_valid, out_mem_data, out_alu_result, out_reg_dest, out_ctrl
  );

  // Pipeline stage side
  modport slave (
    input  in_valid, in_mem_data, in_alu_result, in_reg_dest, in_ctrl, out_ready,
    output in_ready, out_valid, out_mem_data, out_alu_result, out_reg_dest, out_ctrl
  );

endinterface

// File: rtl/mem_wb_stage_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// out_valid, in_ready and out_data are all registered.
module skid_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  sb_state_t    state;
  logic [W-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SB_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Payload registers are left stale; only occupancy is cleared.
      state     <= SB_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        SB_EMPTY: begin
          if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= SB_ONE;
          end
        end
        SB_ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= SB_EMPTY;
          end else if (in_xfer) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state    <= SB_FULL;
          end
        end
        SB_FULL: begin
          if (out_xfer) begin
            out_data <= skid_q;
            in_ready <= 1'b1;
            state    <= SB_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= SB_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: packs the WB payload through a skid buffer, masks WB
// control on bubbles and counts stalled output cycles (saturating).
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  mem_wb_stage_if.slave    bus,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned PW = payload_w(DATA_W, REG_W, CTRL_W);

  logic [PW-1:0]     in_payload;
  logic [PW-1:0]     out_payload;
  logic [CTRL_W-1:0] held_ctrl;

  assign in_payload = {bus.in_mem_data, bus.in_alu_result, bus.in_reg_dest, bus.in_ctrl};

  skid_buffer #(.W(PW)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign {bus.out_mem_data, bus.out_alu_result, bus.out_reg_dest, held_ctrl} = out_payload;
  assign bus.out_ctrl = bus.out_valid ? held_ctrl : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand sequences and random
// traffic checked against a capacity-2 FIFO reference model.
module tb_mem_wb_stage;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 2;
  localparam int unsigned NW = 4;
  localparam int unsigned SAT = (1 << NW) - 1;

  logic          clock;
  logic          reset_n;
  logic          flush;
  logic [NW-1:0] stall_cycles;

  mem_wb_stage_if #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW)) bus ();

  mem_wb_stage #(.DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .bus          (bus.slave),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] mem;
    logic [DW-1:0] alu;
    logic [RW-1:0] dest;
    logic [CW-1:0] ctrl;
  } ent_t;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [DW-1:0] alu;
    logic [CW-1:0] ctrl;
    logic          eov;
    logic          eir;
    logic [DW-1:0] ealu;
    logic [CW-1:0] ectrl;
  } vec_t;

  ent_t        mq[$];
  int unsigned exp_stall;
  int          checks;
  int          failures;
  vec_t        vt[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [DW-1:0] alu, input logic [CW-1:0] ctrl);
    bus.in_valid      = iv;
    bus.out_ready     = ordy;
    flush             = fl;
    bus.in_alu_result = alu;
    bus.in_mem_data   = ~alu;
    bus.in_reg_dest   = alu[RW-1:0] ^ RW'(7);
    bus.in_ctrl       = ctrl;
  endtask

  task automatic model_check();
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
    chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    if (mq.size() > 0) begin
      chk("out_alu_result", 64'(bus.out_alu_result), 64'(mq[0].alu));
      chk("out_mem_data", 64'(bus.out_mem_data), 64'(mq[0].mem));
      chk("out_reg_dest", 64'(bus.out_reg_dest), 64'(mq[0].dest));
      chk("out_ctrl", 64'(bus.out_ctrl), 64'(mq[0].ctrl));
    end else begin
      chk("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
    end
  endtask

  // One clock: evaluate transfers on pre-edge state, then advance the model and compare.
  task automatic step();
    ent_t cur;
    bit   ix;
    bit   ox;
    bit   fl;
    cur = '{mem: bus.in_mem_data, alu: bus.in_alu_result, dest: bus.in_reg_dest, ctrl: bus.in_ctrl};
    ix  = bus.in_valid && (mq.size() < 2);
    ox  = (mq.size() > 0) && bus.out_ready;
    fl  = flush;
    if ((mq.size() > 0) && !bus.out_ready && (exp_stall < SAT)) exp_stall++;
    @(posedge clock);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (ox) void'(mq.pop_front());
      if (ix) mq.push_back(cur);
    end
    model_check();
  endtask

  task automatic async_reset_check();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_alu", 64'(bus.out_alu_result), 64'd0);
    mq.delete();
    exp_stall = 0;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_stall = 0;
    reset_n   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clock);
    chk("init_out_valid", 64'(bus.out_valid), 64'd0);
    chk("init_in_ready", 64'(bus.in_ready), 64'd1);
    chk("init_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("init_stall", 64'(stall_cycles), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    //           iv   ordy fl   alu        ctrl   eov  eir  ealu       ectrl
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h1,  2'b10, 1'b1, 1'b1, 32'h1,  2'b10};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h2,  2'b10, 1'b1, 1'b1, 32'h2,  2'b10};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h3,  2'b10, 1'b1, 1'b1, 32'h3,  2'b10};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  2'b10, 1'b0, 1'b1, 32'h0,  2'b00};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'hA,  2'b10, 1'b1, 1'b1, 32'hA,  2'b10};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'hB,  2'b10, 1'b1, 1'b0, 32'hA,  2'b10};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'hC,  2'b10, 1'b1, 1'b0, 32'hA,  2'b10};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  2'b10, 1'b1, 1'b1, 32'hB,  2'b10};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  2'b10, 1'b0, 1'b1, 32'h0,  2'b00};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h11, 2'b10, 1'b1, 1'b1, 32'h11, 2'b10};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h12, 2'b10, 1'b1, 1'b0, 32'h11, 2'b10};
    vt[11] = '{1'b1, 1'b0, 1'b1, 32'h13, 2'b10, 1'b0, 1'b1, 32'h0,  2'b00};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,  2'b10, 1'b0, 1'b1, 32'h0,  2'b00};
    vt[13] = '{1'b0, 1'b1, 1'b0, 32'h0,  2'b11, 1'b0, 1'b1, 32'h0,  2'b00};
    vt[14] = '{1'b1, 1'b0, 1'b0, 32'h20, 2'b01, 1'b1, 1'b1, 32'h20, 2'b01};
    vt[15] = '{1'b1, 1'b0, 1'b1, 32'h21, 2'b10, 1'b0, 1'b1, 32'h0,  2'b00};
    vt[16] = '{1'b0, 1'b1, 1'b0, 32'h0,  2'b11, 1'b0, 1'b1, 32'h0,  2'b00};

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].alu, vt[i].ctrl);
      step();
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(vt[i].eov));
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(vt[i].eir));
      chk($sformatf("tbl%0d_out_ctrl", i), 64'(bus.out_ctrl), 64'(vt[i].ectrl));
      if (vt[i].eov) chk($sformatf("tbl%0d_out_alu", i), 64'(bus.out_alu_result), 64'(vt[i].ealu));
      if (!bus.out_valid) chk($sformatf("tbl%0d_no_regwrite", i), 64'(bus.out_ctrl[CTRL_REGWRITE]), 64'd0);
    end

    // Stall counter saturation: one held entry, 20 stalled cycles.
    async_reset_check();
    drive(1'b1, 1'b0, 1'b0, 32'h55, 2'b11);
    step();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b11);
      step();
      chk($sformatf("stall_run%0d", i), 64'(stall_cycles), 64'((i < 15) ? i : 15));
    end
    chk("stall_saturated", 64'(stall_cycles), 64'd15);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 2'b00);
    step();
    chk("stall_kept_by_flush", 64'(stall_cycles), 64'd15);

    // Reset arriving while FULL drops both entries.
    drive(1'b1, 1'b0, 1'b0, 32'h77, 2'b10);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h78, 2'b10);
    step();
    chk("full_before_reset", 64'(bus.in_ready), 64'd0);
    async_reset_check();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
    step();

    for (int i = 0; i < 300; i++) begin
      drive(1'b1 & ($urandom_range(0, 3) != 0), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom, CW'($urandom));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
